// File: rtl/ex_result_stage.sv
// Execute-stage output register behind the ALU: resolves conditional branches
// at accept and hands entries downstream through a 2-entry (main + skid) buffer.
module ex_result_stage #(
    parameter int C_WIDTH = 8,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [C_WIDTH-1:0] in_result,
    input  logic [3:0]         in_status,
    input  logic [RA_W-1:0]    in_rd,
    input  logic               in_we,
    input  logic               in_branch,
    input  logic [2:0]         in_funct3,
    input  logic [C_WIDTH-1:0] in_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [C_WIDTH-1:0] out_result,
    output logic [3:0]         out_status,
    output logic [RA_W-1:0]    out_rd,
    output logic               out_we,
    output logic               out_taken,
    output logic [C_WIDTH-1:0] out_target,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   taken_cnt
);

    typedef struct packed {
        logic [C_WIDTH-1:0] result;
        logic [3:0]         status;
        logic [RA_W-1:0]    rd;
        logic               we;
        logic               taken;
        logic [C_WIDTH-1:0] target;
        logic               illegal;
    } entry_t;

    entry_t             r_main;
    entry_t             r_skid;
    entry_t             w_new;
    logic               r_main_vld;
    logic               r_skid_vld;
    logic [CNT_W-1:0]   r_taken_cnt;
    logic               w_accept;
    logic               w_pop;
    logic               w_taken;
    logic               w_illegal;
    logic               w_n;
    logic               w_z;
    logic               w_c;
    logic               w_v;

    assign {w_n, w_z, w_c, w_v} = in_status;

    // Branch outcome is frozen at accept so the stored flags never need re-evaluation.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        if (in_branch) begin
            case (in_funct3)
                3'b000:  w_taken = w_z;
                3'b001:  w_taken = ~w_z;
                3'b100:  w_taken = w_n ^ w_v;
                3'b101:  w_taken = ~(w_n ^ w_v);
                3'b110:  w_taken = w_c;
                3'b111:  w_taken = ~w_c;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_new.result  = in_result;
        w_new.status  = in_status;
        w_new.rd      = in_rd;
        w_new.we      = in_we & ~in_branch;
        w_new.taken   = w_taken;
        w_new.target  = in_target;
        w_new.illegal = w_illegal;
    end

    assign in_ready = ~r_skid_vld;
    assign w_accept = in_valid & ~r_skid_vld;
    assign w_pop    = r_main_vld & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            if (w_pop) begin
                r_main     <= r_skid;
                r_skid_vld <= 1'b0;
            end
        end else if (!r_main_vld || w_pop) begin
            r_main_vld <= w_accept;
            if (w_accept) begin
                r_main <= w_new;
            end
        end else if (w_accept) begin
            r_skid     <= w_new;
            r_skid_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt <= '0;
        end else if (!flush && w_pop && r_main.taken && (r_taken_cnt != '1)) begin
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_main_vld;
    assign out_result  = r_main.result;
    assign out_status  = r_main.status;
    assign out_rd      = r_main.rd;
    assign out_we      = r_main.we;
    assign out_taken   = r_main.taken;
    assign out_target  = r_main.target;
    assign out_illegal = r_main.illegal;
    assign taken_cnt   = r_taken_cnt;

endmodule
